// File: rtl/probe_latency_meter.sv
// probe_latency_meter: periodic request/acknowledge probe. Every PERIOD cycles
// it raises req and counts the busy, not-yet-acknowledged cycles of the
// responder. It publishes that count and tracks the running maximum, aborted
// rounds (timeout) and rounds that outlast the period (sticky overrun).
module probe_latency_meter #(
    parameter int LAT_W   = 8,
    parameter int CNT_W   = 16,
    parameter int PERIOD  = 500,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             busy_in,
    input  logic             ack_in,
    input  logic             clr_stats,
    output logic             req,
    output logic [LAT_W-1:0] lat_out,
    output logic             lat_valid,
    output logic [LAT_W-1:0] lat_max,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSERT   = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PCNT_LOAD = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_ZERO  = LAT_W'(0);
    localparam logic [LAT_W-1:0] LAT_SAT   = {LAT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             req_q, req_d;
    logic [LAT_W-1:0] lat_out_q, lat_out_d;
    logic             lat_valid_q, lat_valid_d;
    logic [LAT_W-1:0] lat_max_q, lat_max_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;

    logic             start_s;     // entering ASSERT on this edge
    logic             publish_s;   // acknowledged round completes on this edge
    logic             ovr_hit_s;   // period expired while the round is still open
    logic [LAT_W-1:0] max_base_s;  // running maximum after an optional clear

    // Round sequencing: state transitions, req and the one-cycle result pulses.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        lat_valid_d = 1'b0;
        timeout_d   = 1'b0;
        start_s     = 1'b0;
        publish_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ASSERT;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                state_d = ST_WAIT_ACK;
                req_d   = 1'b1;
            end
            ST_WAIT_ACK: begin
                // An ack arriving on the last allowed cycle still counts as a result.
                if (ack_in) begin
                    state_d     = ST_WAIT_REL;
                    req_d       = 1'b0;
                    lat_valid_d = 1'b1;
                    publish_s   = 1'b1;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d   = ST_WAIT_REL;
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_REL: begin
                req_d = 1'b0;
                if (!ack_in) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            ST_HOLD: begin
                if (pcnt_q == CNT_ZERO) begin
                    if (enable) begin
                        state_d = ST_ASSERT;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Counters and statistics: period/wait/latency counts, latest result, max, overrun.
    always_comb begin
        pcnt_d     = pcnt_q;
        wcnt_d     = wcnt_q;
        lat_cnt_d  = lat_cnt_q;
        lat_out_d  = lat_out_q;
        lat_max_d  = lat_max_q;
        overrun_d  = overrun_q;
        max_base_s = lat_max_q;
        ovr_hit_s  = 1'b0;

        // Period counter is reloaded on every round start and otherwise runs down to 0.
        if (start_s) begin
            pcnt_d = PCNT_LOAD;
        end else if (pcnt_q != CNT_ZERO) begin
            pcnt_d = pcnt_q - CNT_ONE;
        end else begin
            pcnt_d = CNT_ZERO;
        end

        // The ack cycle is excluded from the latency, and the count saturates.
        if (start_s) begin
            wcnt_d    = CNT_ZERO;
            lat_cnt_d = LAT_ZERO;
        end else if (state_q == ST_WAIT_ACK) begin
            wcnt_d = wcnt_q + CNT_ONE;
            if (busy_in && !ack_in && (lat_cnt_q != LAT_SAT)) begin
                lat_cnt_d = lat_cnt_q + LAT_ONE;
            end else begin
                lat_cnt_d = lat_cnt_q;
            end
        end else begin
            wcnt_d    = wcnt_q;
            lat_cnt_d = lat_cnt_q;
        end

        // A clear that coincides with a new result leaves that result as the maximum.
        if (clr_stats) begin
            max_base_s = LAT_ZERO;
        end else begin
            max_base_s = lat_max_q;
        end

        if (publish_s) begin
            lat_out_d = lat_cnt_q;
            lat_max_d = (lat_cnt_q > max_base_s) ? lat_cnt_q : max_base_s;
        end else begin
            lat_out_d = lat_out_q;
            lat_max_d = max_base_s;
        end

        // Setting overrun wins over a simultaneous clear.
        ovr_hit_s = ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_REL)) &&
                    (pcnt_q == CNT_ZERO);
        if (ovr_hit_s) begin
            overrun_d = 1'b1;
        end else if (clr_stats) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pcnt_q      <= CNT_ZERO;
            wcnt_q      <= CNT_ZERO;
            lat_cnt_q   <= LAT_ZERO;
            req_q       <= 1'b0;
            lat_out_q   <= LAT_ZERO;
            lat_valid_q <= 1'b0;
            lat_max_q   <= LAT_ZERO;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            wcnt_q      <= wcnt_d;
            lat_cnt_q   <= lat_cnt_d;
            req_q       <= req_d;
            lat_out_q   <= lat_out_d;
            lat_valid_q <= lat_valid_d;
            lat_max_q   <= lat_max_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign req       = req_q;
    assign lat_out   = lat_out_q;
    assign lat_valid = lat_valid_q;
    assign lat_max   = lat_max_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_probe_latency_meter.sv
// Bench for probe_latency_meter: directed sequences for the latency, saturation,
// timeout, overrun/clear and reset corners, then randomized rounds checked against
// a round-level timeline model, on an 8-bit/20-cycle and a 4-bit/60-cycle instance.
module tb_probe_latency_meter;

    localparam int NV = 2500;

    logic clock;
    logic reset, enable, busy_in, ack_in, clr_stats;
    logic       a_req, a_valid, a_to, a_ovr;
    logic [7:0] a_lat, a_max;
    logic       b_req, b_valid, b_to, b_ovr;
    logic [3:0] b_lat, b_max;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    probe_latency_meter #(.LAT_W(8), .CNT_W(16), .PERIOD(20), .TIMEOUT(12)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .busy_in(busy_in),
        .ack_in(ack_in), .clr_stats(clr_stats), .req(a_req), .lat_out(a_lat),
        .lat_valid(a_valid), .lat_max(a_max), .timeout(a_to), .overrun(a_ovr)
    );

    probe_latency_meter #(.LAT_W(4), .CNT_W(16), .PERIOD(60), .TIMEOUT(40)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .busy_in(busy_in),
        .ack_in(ack_in), .clr_stats(clr_stats), .req(b_req), .lat_out(b_lat),
        .lat_valid(b_valid), .lat_max(b_max), .timeout(b_to), .overrun(b_ovr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One record per clock edge: inputs applied before the edge, outputs expected after it.
    typedef struct {
        logic       rst, en, busy, ack, clr;
        logic       xreq, xvalid, xto, xovr;
        logic [7:0] xlat, xmax;
    } vec_t;

    vec_t       vecs    [NV];
    bit         upd     [NV];
    logic [7:0] upd_val [NV];
    bit         ovset   [NV];
    bit         tpulse  [NV];
    bit         reqx    [NV];

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits for req of the 8-bit instance to go high; returns the cycle it was seen.
    task automatic wait_rise(input int bound, input string name, output int t);
        bit seen;
        seen = 1'b0;
        t    = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (a_req === 1'b1) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no req rise within %0d cycles", name, bound);
        end
    endtask

    // Called on the first WAIT_ACK cycle: npre pre-ack cycles with busy from pat,
    // then an ack cycle with busy high, then release.
    task automatic round_a(input logic [15:0] pat, input int npre, input int exp_lat,
                           input int exp_max, input string tag);
        for (int k = 0; k < npre; k++) begin
            busy_in = pat[k];
            ack_in  = 1'b0;
            step();
        end
        busy_in = 1'b1;
        ack_in  = 1'b1;
        step();
        chk({tag, "_lat_out"}, a_lat, exp_lat);
        chk({tag, "_valid_to_req"}, {a_valid, a_to, a_req}, 3'b100);
        chk({tag, "_lat_max"}, a_max, exp_max);
        ack_in  = 1'b0;
        busy_in = 1'b0;
        step();
        chk({tag, "_valid_single"}, a_valid, 1'b0);
    endtask

    // Timeline model: schedules whole rounds from the protocol rules (req rise one edge
    // after the round start, ack/timeout edge, release, next start at
    // max(start+PERIOD, hold_entry+1)), then folds result, clear and overrun events
    // into the expected outputs.
    task automatic build_random(input int P, input int T, input int LMAX, output int len);
        int   a0, a, e1, h, x, r, g, cnt, lat;
        bit   acked;
        logic [7:0] lo, mx;
        bit   ov;
        for (int n = 0; n < NV; n++) begin
            vecs[n].rst  = (n < 3);
            vecs[n].en   = ($urandom_range(0, 1) != 0);
            vecs[n].busy = ($urandom_range(0, 3) != 0);
            vecs[n].ack  = ($urandom_range(0, 1) != 0);
            vecs[n].clr  = ($urandom_range(0, 29) == 0);
            upd[n] = 1'b0; upd_val[n] = 8'd0; ovset[n] = 1'b0; tpulse[n] = 1'b0; reqx[n] = 1'b0;
        end
        a0 = 3 + $urandom_range(0, 3);
        for (int n = 3; n < a0; n++) vecs[n].en = 1'b0;
        vecs[a0].en = 1'b1;
        while (a0 + T + 3 * P + 20 < NV) begin
            acked = ($urandom_range(0, 5) != 0);
            a     = acked ? $urandom_range(0, T - 1) : T - 1;
            cnt   = 0;
            for (int k = 0; k <= a; k++) begin
                vecs[a0 + 2 + k].ack = acked && (k == a);
                if (vecs[a0 + 2 + k].busy && !vecs[a0 + 2 + k].ack) cnt++;
            end
            lat = (cnt > LMAX) ? LMAX : cnt;
            e1  = a0 + 2 + a;
            for (int n = a0 + 1; n < e1; n++) reqx[n] = 1'b1;
            if (acked) begin
                upd[e1]     = 1'b1;
                upd_val[e1] = 8'(lat);
            end else begin
                tpulse[e1] = 1'b1;
            end
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P) : $urandom_range(0, 2);
            for (int j = 0; j <= r; j++) vecs[e1 + 1 + j].ack = (j < r);
            h = e1 + 1 + r;
            for (int n = a0 + P; n <= h; n++) ovset[n] = 1'b1;
            x = (a0 + P > h + 1) ? a0 + P : h + 1;
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            vecs[x].en = (g == 0);
            for (int n = x + 1; n < x + g; n++) vecs[n].en = 1'b0;
            if (g > 0) vecs[x + g].en = 1'b1;
            a0 = x + g;
        end
        len = a0 + 1;
        lo = 8'd0; mx = 8'd0; ov = 1'b0;
        for (int n = 0; n < len; n++) begin
            if (vecs[n].rst) begin
                lo = 8'd0; mx = 8'd0; ov = 1'b0;
            end else begin
                if (vecs[n].clr) begin
                    mx = 8'd0;
                    ov = 1'b0;
                end
                if (upd[n]) begin
                    lo = upd_val[n];
                    if (upd_val[n] > mx) mx = upd_val[n];
                end
                if (ovset[n]) ov = 1'b1;
            end
            vecs[n].xreq   = reqx[n];
            vecs[n].xvalid = upd[n];
            vecs[n].xto    = tpulse[n];
            vecs[n].xlat   = lo;
            vecs[n].xmax   = mx;
            vecs[n].xovr   = ov;
        end
    endtask

    task automatic apply(input int len, input bit sel);
        logic [19:0] act, exp;
        for (int n = 0; n < len; n++) begin
            reset     = vecs[n].rst;
            enable    = vecs[n].en;
            busy_in   = vecs[n].busy;
            ack_in    = vecs[n].ack;
            clr_stats = vecs[n].clr;
            step();
            if (sel) act = {b_req, 4'd0, b_lat, b_valid, 4'd0, b_max, b_to, b_ovr};
            else     act = {a_req, a_lat, a_valid, a_max, a_to, a_ovr};
            exp = {vecs[n].xreq, vecs[n].xlat, vecs[n].xvalid, vecs[n].xmax,
                   vecs[n].xto, vecs[n].xovr};
            chk($sformatf("rand%0d_vec%0d", sel, n), {12'd0, act}, {12'd0, exp});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t_rel, t1, t2, t3, t4, t5, t6, t7, th, n, len;
        reset = 1'b1; enable = 1'b0; busy_in = 1'b0; ack_in = 1'b0; clr_stats = 1'b0;
        step();
        step();
        chk("reset_outputs", {a_req, a_lat, a_valid, a_max, a_to, a_ovr}, 0);

        // Basic latency: 5 busy cycles then ack on the 6th WAIT_ACK cycle.
        reset = 1'b0; enable = 1'b1; busy_in = 1'b1;
        t_rel = cyc;
        wait_rise(10, "first_rise", t1);
        chk("first_rise_delay", t1 - t_rel, 2);
        round_a(16'h001F, 5, 5, 5, "basic");
        wait_rise(40, "basic_next", t2);
        chk("basic_period", t2 - t1, 20);

        // Busy qualifier (3 of 7) and running max across rounds of 3 and 7.
        round_a(16'h0052, 7, 3, 5, "qual");
        wait_rise(40, "qual_next", t3);
        chk("qual_period", t3 - t2, 20);
        round_a(16'h007F, 7, 7, 7, "max7");
        wait_rise(40, "max7_next", t4);

        // Timeout: no ack for the whole window.
        busy_in = 1'b1; ack_in = 1'b0;
        n = 0;
        while (a_req === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("tmo_req_cycles", n, 12);
        chk("tmo_pulse", {a_to, a_valid}, 2'b10);
        chk("tmo_lat_kept", {a_lat, a_max}, {8'd7, 8'd7});
        step();
        chk("tmo_single_pulse", a_to, 1'b0);
        wait_rise(40, "tmo_next", t5);
        chk("tmo_period", t5 - t4, 20);

        // Overrun: ack held high for 25 cycles of the round, then released.
        ack_in = 1'b1;
        for (int i = 0; i < 25; i++) step();
        ack_in = 1'b0;
        step();
        th = cyc;
        chk("ovr_set", {a_ovr, a_req, a_lat, a_max}, {1'b1, 1'b0, 8'd0, 8'd7});
        wait_rise(10, "ovr_next", t6);
        chk("ovr_hold_to_rise", t6 - th, 2);
        chk("ovr_stretched_period", t6 - t5, 28);

        // Clear statistics mid-round, then finish with a 2-cycle latency.
        busy_in = 1'b1; clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_stats", {a_ovr, a_max}, 0);
        round_a(16'h0001, 1, 2, 2, "after_clr");
        chk("clr_ovr_stays", a_ovr, 1'b0);
        wait_rise(40, "clr_next", t7);
        chk("clr_period", t7 - t6, 20);

        // Reset during WAIT_ACK, coinciding with an ack.
        busy_in = 1'b1; ack_in = 1'b0;
        step(); step(); step();
        reset = 1'b1; ack_in = 1'b1;
        step();
        chk("midreset_outputs", {a_req, a_lat, a_valid, a_max, a_to, a_ovr}, 0);
        reset = 1'b0; ack_in = 1'b0; enable = 1'b1;
        t_rel = cyc;
        wait_rise(10, "midreset_rise", t1);
        chk("midreset_rise_delay", t1 - t_rel, 2);

        // Saturation on the 4-bit instance: 20 busy cycles must read 15, not 4.
        reset = 1'b1;
        step();
        reset = 1'b0; enable = 1'b1; busy_in = 1'b1; ack_in = 1'b0;
        step();
        step();
        chk("sat_req_up", b_req, 1'b1);
        for (int i = 0; i < 20; i++) step();
        ack_in = 1'b1;
        step();
        chk("sat_lat_out", b_lat, 4'd15);
        chk("sat_lat_max", b_max, 4'd15);
        chk("sat_valid", {b_valid, b_to, b_req}, 3'b100);
        ack_in = 1'b0;
        step();

        // Randomized rounds against the timeline model on both instances.
        build_random(20, 12, 255, len);
        apply(len, 1'b0);
        build_random(60, 40, 15, len);
        apply(len, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/probe_latency_meter.md
Name: probe_latency_meter

Overview:
- Periodic request/acknowledge probe that measures the latency of an external responder.
- Every PERIOD cycles it raises req, counts the cycles in which the responder is busy and has not yet acknowledged, then publishes the count.
- Also tracks the running maximum, waiting-for-ack timeout and period overrun.
- Sits between a status/debug register bank and the peripheral under observation. It is the configurable successor of the fixed 8-bit single-shot delay meter.

Parameters:
- LAT_W, 8: width of latency count, lat_out and lat_max.
- CNT_W, 16: width of the period counter and the wait counter.
- PERIOD, 500: cycles between consecutive req rising edges. Constraint: 4 <= PERIOD <= 2^CNT_W.
- TIMEOUT, 255: maximum number of WAIT_ACK cycles before the round is aborted. Constraint: 1 <= TIMEOUT < 2^CNT_W.

Ports:
- clock, in, 1: single clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: start/continue periodic rounds.
- busy_in, in, 1: responder busy qualifier (counted cycles).
- ack_in, in, 1: responder acknowledge.
- clr_stats, in, 1: synchronous clear of lat_max and overrun.
- req, out, 1: probe request, registered.
- lat_out, out, LAT_W: last measured latency.
- lat_valid, out, 1: one-cycle pulse when lat_out updates.
- lat_max, out, LAT_W: maximum latency since reset/clr_stats.
- timeout, out, 1: one-cycle pulse on an aborted round.
- overrun, out, 1: sticky; a round did not finish within PERIOD.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, req=0, lat_out=0, lat_valid=0, lat_max=0, timeout=0, overrun=0, all internal counters 0.
- Reset has priority over every other input. Reset mid-round aborts the round: req=0 at the following edge, no lat_valid and no timeout pulse.
- All outputs are registered.
- States: IDLE, ASSERT, WAIT_ACK, WAIT_REL, HOLD.
- IDLE: enable=1 -> ASSERT.
- ASSERT (exactly 1 cycle):
  - pcnt was loaded with PERIOD-1 on the entry edge; lat_cnt=0, wcnt=0.
  - Exit edge: req<=1 -> WAIT_ACK.
- pcnt: decrements every cycle while nonzero and holds at 0. Consecutive ASSERT entries are therefore exactly PERIOD cycles apart when no overrun occurs.
- WAIT_ACK:
  - If busy_in=1 and ack_in=0: lat_cnt increments, saturating at 2^LAT_W-1 (no wrap). The ack cycle itself is never counted.
  - wcnt increments every cycle.
  - ack_in=1 -> WAIT_REL. On that edge: req<=0, lat_out<=lat_cnt, lat_valid<=1, lat_max<=max(lat_max, lat_cnt).
  - ack_in=0 and wcnt==TIMEOUT-1 -> WAIT_REL. On that edge: req<=0, timeout<=1; lat_out and lat_max unchanged; no lat_valid.
- WAIT_REL: ack_in=0 -> HOLD. Otherwise stay; req stays 0.
- HOLD: pcnt==0 -> ASSERT if enable=1, else IDLE.
- enable low mid-round: the round completes normally; exit from HOLD goes to IDLE.
- Overrun:
  - overrun<=1 if pcnt==0 while in WAIT_ACK or WAIT_REL.
  - HOLD is then left on the cycle after entry (pcnt already 0); the round is stretched, never shortened.
- clr_stats=1: lat_max<=0 and overrun<=0 at the next edge. If it coincides with a latency update, lat_max<=lat_cnt. If it coincides with an overrun set, overrun<=1 (set wins).
- lat_valid and timeout are never asserted in the same cycle.

Test Plan:
1. Basic latency: LAT_W=8, PERIOD=20, TIMEOUT=12, enable=1. ack_in rises on the 6th WAIT_ACK cycle, busy_in=1 throughout -> lat_out=5, single-cycle lat_valid, req falls on the same edge, next req rise exactly 20 cycles after the previous one.
2. Qualifier and max tracking: busy_in high on 3 of 7 pre-ack cycles and also during the ack cycle -> lat_out=3. Three rounds measuring 5, 3, 7 -> lat_max reads 5, 5, 7.
3. Saturation: LAT_W=4, PERIOD=60, TIMEOUT=40. busy_in=1 for 20 cycles, then ack -> lat_out=15 and lat_max=15, with no wrap.
4. Timeout: PERIOD=20, TIMEOUT=12, ack_in held 0 -> req drops after 12 WAIT_ACK cycles, timeout pulses once, lat_out unchanged, next req rise still at cycle 20.
5. Overrun and clear: PERIOD=20, ack_in held high until cycle 25 of the round -> overrun=1, next ASSERT 2 cycles after HOLD entry. Then clr_stats=1 for one cycle -> overrun=0 and lat_max=0.
6. Reset mid-round: reset=1 during WAIT_ACK -> next edge req=0, lat_out=0, lat_max=0, state IDLE. With enable=1 after reset release, the first req rises 2 cycles later.
